// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the iterative-unit FSM state type
// for the multi-cycle ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b000111;
    localparam logic [5:0] OP_SUB = 6'b001000;
    localparam logic [5:0] OP_AND = 6'b001001;
    localparam logic [5:0] OP_OR  = 6'b001010;
    localparam logic [5:0] OP_XOR = 6'b001011;
    localparam logic [5:0] OP_LSL = 6'b001100;
    localparam logic [5:0] OP_LSR = 6'b001101;
    localparam logic [5:0] OP_MUL = 6'b001110;
    localparam logic [5:0] OP_DIV = 6'b001111;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle signed multiply (shift-add) and divide (restoring) engine.
// Works on operand magnitudes and applies the result sign on the final step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_next;
    logic [CW-1:0]      count;
    logic               op_div, neg, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc, mcand, acc_step, mcand_step, product;
    logic [WIDTH-1:0]   mplier, mplier_step;
    logic [WIDTH-1:0]   rem, quo, dvsr, rem_step, quo_step, quotient;
    logic [WIDTH:0]     shifted, trial;

    always_comb begin
        state_next = state;
        last       = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (count == LAST_COUNT) begin
                    state_next = ST_IDLE;
                    last       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result on the last step is taken from the step outputs so it lands with DONE.
    always_comb begin
        a_mag       = a[WIDTH-1] ? -a : a;
        b_mag       = b[WIDTH-1] ? -b : b;
        acc_step    = mplier[0] ? acc + mcand : acc;
        mcand_step  = mcand << 1;
        mplier_step = mplier >> 1;
        shifted     = {rem, quo[WIDTH-1]};
        trial       = shifted - {1'b0, dvsr};
        if (trial[WIDTH]) begin
            rem_step = shifted[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end
        product  = neg ? -acc_step : acc_step;
        quotient = neg ? -quo_step : quo_step;
        result   = op_div ? quotient : product[WIDTH-1:0];
        ovf      = op_div ? div_ovf
                          : ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            op_div  <= 1'b0;
            neg     <= 1'b0;
            div_ovf <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
        end else if (en) begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                count   <= '0;
                op_div  <= is_div;
                neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                div_ovf <= (a == MIN_VAL) && (b == '1);
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, a_mag};
                mplier  <= b_mag;
                rem     <= '0;
                quo     <= a_mag;
                dvsr    <= b_mag;
            end else if (state == ST_RUN) begin
                count  <= last ? '0 : count + 1'b1;
                acc    <= acc_step;
                mcand  <= mcand_step;
                mplier <= mplier_step;
                rem    <= rem_step;
                quo    <= quo_step;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: operands are captured on accept, single-cycle ops resolve on the
// next edge, MUL/DIV are handed to the iterative engine.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             START,
    input  logic [5:0]       OPCODE,
    input  logic [WIDTH-1:0] ACC,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] IMMEDIATE,
    input  logic             REGISTER_ADDRESS,
    input  logic             USE_IMM,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sel_reg, op_a, op_b;
    logic             cap_valid;
    logic [5:0]       cap_op;
    logic [WIDTH-1:0] cap_a, cap_b;
    logic             accept, pending_multi;
    logic             iter_busy, iter_last, iter_ovf;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH:0]   sum, diff, shl, shr;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] value, res_next;
    logic [3:0]       flags_next;
    logic             carry, ovf, update, done_next, done_q;

    // A captured MUL/DIV blocks new requests until the engine has picked it up.
    always_comb begin
        sel_reg       = REGISTER_ADDRESS ? Y : X;
        op_a          = USE_IMM ? sel_reg : ACC;
        op_b          = USE_IMM ? IMMEDIATE : sel_reg;
        pending_multi = cap_valid && (cap_op == OP_MUL || (cap_op == OP_DIV && cap_b != '0));
        accept        = START && !iter_busy && !pending_multi;
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (CLK),
        .rst    (RST),
        .en     (EN),
        .start  (pending_multi),
        .is_div (cap_op == OP_DIV),
        .a      (cap_a),
        .b      (cap_b),
        .busy   (iter_busy),
        .last   (iter_last),
        .result (iter_result),
        .ovf    (iter_ovf)
    );

    always_comb begin
        amt        = cap_b[SHW-1:0];
        sum        = {1'b0, cap_a} + {1'b0, cap_b};
        diff       = {1'b0, cap_a} - {1'b0, cap_b};
        shl        = {1'b0, cap_a} << amt;
        shr        = {cap_a, 1'b0} >> amt;
        value      = res;
        carry      = 1'b0;
        ovf        = 1'b0;
        update     = 1'b0;
        done_next  = 1'b0;
        res_next   = res;
        flags_next = flags;
        if (iter_last) begin
            value     = iter_result;
            ovf       = iter_ovf;
            update    = 1'b1;
            done_next = 1'b1;
        end else if (cap_valid) begin
            update    = 1'b1;
            done_next = 1'b1;
            case (cap_op)
                OP_ADD: begin
                    value = sum[WIDTH-1:0];
                    carry = sum[WIDTH];
                    ovf   = (cap_a[WIDTH-1] == cap_b[WIDTH-1]) && (sum[WIDTH-1] != cap_a[WIDTH-1]);
                end
                OP_SUB: begin
                    value = diff[WIDTH-1:0];
                    carry = diff[WIDTH];
                    ovf   = (cap_a[WIDTH-1] != cap_b[WIDTH-1]) && (diff[WIDTH-1] != cap_a[WIDTH-1]);
                end
                OP_AND: value = cap_a & cap_b;
                OP_OR:  value = cap_a | cap_b;
                OP_XOR: value = cap_a ^ cap_b;
                OP_LSL: begin
                    value = shl[WIDTH-1:0];
                    carry = shl[WIDTH];
                end
                OP_LSR: begin
                    value = shr[WIDTH:1];
                    carry = shr[0];
                end
                OP_MUL: begin
                    update    = 1'b0;
                    done_next = 1'b0;
                end
                OP_DIV: begin
                    if (cap_b == '0) begin
                        value = '1;
                        ovf   = 1'b1;
                    end else begin
                        update    = 1'b0;
                        done_next = 1'b0;
                    end
                end
                default: update = 1'b0;
            endcase
        end
        // Undefined opcodes complete with DONE but leave res alone and clear flags.
        if (update) begin
            res_next           = value;
            flags_next[FLAG_V] = ovf;
            flags_next[FLAG_C] = carry;
            flags_next[FLAG_N] = value[WIDTH-1];
            flags_next[FLAG_Z] = (value == '0);
        end else if (done_next) begin
            flags_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_valid <= 1'b0;
            cap_op    <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            res       <= '0;
            flags     <= '0;
            done_q    <= 1'b0;
        end else if (EN) begin
            cap_valid <= accept;
            if (accept) begin
                cap_op <= OPCODE;
                cap_a  <= op_a;
                cap_b  <= op_b;
            end
            res    <= res_next;
            flags  <= flags_next;
            done_q <= done_next;
        end
    end

    assign BUSY = iter_busy;
    assign DONE = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (WIDTH=16): directed vector table, randomized ops against an
// arithmetic reference model, and hand-written back-to-back / reset / enable sequences.
module tb_alu_multicycle;

    localparam logic [5:0] C_ADD = 6'b000111;
    localparam logic [5:0] C_SUB = 6'b001000;
    localparam logic [5:0] C_AND = 6'b001001;
    localparam logic [5:0] C_OR  = 6'b001010;
    localparam logic [5:0] C_XOR = 6'b001011;
    localparam logic [5:0] C_LSL = 6'b001100;
    localparam logic [5:0] C_LSR = 6'b001101;
    localparam logic [5:0] C_MUL = 6'b001110;
    localparam logic [5:0] C_DIV = 6'b001111;
    localparam logic [5:0] C_BAD = 6'b111111;
    localparam int NVEC = 18;

    typedef struct {
        logic [5:0]  op;
        logic        ui;
        logic        ra;
        logic [15:0] acc;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] imm;
        logic [15:0] exp_res;
        logic [3:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST, EN, START, REGISTER_ADDRESS, USE_IMM;
    logic [5:0]  OPCODE;
    logic [15:0] ACC, X, Y, IMMEDIATE;
    logic        BUSY, DONE;
    logic [15:0] res;
    logic [3:0]  flags;

    int checks;
    int failures;
    vec_t vectors[NVEC];
    logic [5:0] rand_ops[11];

    alu_multicycle #(.WIDTH(16)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .EN               (EN),
        .START            (START),
        .OPCODE           (OPCODE),
        .ACC              (ACC),
        .X                (X),
        .Y                (Y),
        .IMMEDIATE        (IMMEDIATE),
        .REGISTER_ADDRESS (REGISTER_ADDRESS),
        .USE_IMM          (USE_IMM),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .res              (res),
        .flags            (flags)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Pulses START for one edge and counts edges until DONE, with a hard bound.
    task automatic applyStimulus(input logic [5:0] op, input logic [15:0] acc, x, y, imm,
                                 input logic ra, ui, output int lat, output int busy_cycles,
                                 output logic [15:0] got_res, output logic [3:0] got_flags);
        OPCODE = op; ACC = acc; X = x; Y = y; IMMEDIATE = imm;
        REGISTER_ADDRESS = ra; USE_IMM = ui; START = 1'b1;
        tick();
        START = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (lat < 60) begin
            tick();
            lat++;
            if (BUSY) busy_cycles++;
            if (DONE) break;
        end
        got_res = res;
        got_flags = flags;
    endtask

    // Flags packed as {Z, N, C, V}; undefined opcodes keep prev and clear flags.
    function automatic void refModel(input logic [5:0] op, input logic [15:0] a, b, prev,
                                     output logic [15:0] r, output logic [3:0] f, output int lat);
        longint sa, sb, ua, ub, t, amt;
        logic c, v, known;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a); ub = longint'(b);
        amt = ub % 16;
        r = prev; c = 1'b0; v = 1'b0; lat = 1; known = 1'b1;
        case (op)
            C_ADD: begin t = ua + ub; r = 16'(t); c = (t > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            C_SUB: begin t = sa - sb; r = 16'(t); c = (ua < ub); v = (t > 32767) || (t < -32768); end
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_XOR: r = a ^ b;
            C_LSL: begin r = 16'(ua << amt); c = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0); end
            C_LSR: begin r = 16'(ua >> amt); c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
            C_MUL: begin t = sa * sb; r = 16'(t); v = (t > 32767) || (t < -32768); lat = 17; end
            C_DIV: begin
                if (ub == 0) begin
                    r = 16'hFFFF; v = 1'b1;
                end else begin
                    t = sa / sb; r = 16'(t); v = (t > 32767); lat = 17;
                end
            end
            default: known = 1'b0;
        endcase
        f = known ? {r == 16'h0, r[15], c, v} : 4'b0000;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, busy_cycles, done_seen, busy_seen;
        logic [15:0] got_res, e_res, prev_res, acc, x, y, imm, a, b;
        logic [3:0] got_flags, e_flags;
        logic [5:0] op;
        logic ra, ui;
        int e_lat;

        checks = 0;
        failures = 0;
        vectors[0]  = '{C_ADD, 1'b0, 1'b1, 16'h7FFE, 16'h0000, 16'h0002, 16'h0000, 16'h8000, 4'b0101, 1};
        vectors[1]  = '{C_ADD, 1'b0, 1'b1, 16'h0003, 16'h0000, 16'hFFFD, 16'h0000, 16'h0000, 4'b1010, 1};
        vectors[2]  = '{C_SUB, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFF1, 16'h000E, 4'b0000, 1};
        vectors[3]  = '{C_MUL, 1'b0, 1'b0, 16'hFED4, 16'h00C8, 16'h0000, 16'h0000, 16'h15A0, 4'b0001, 17};
        vectors[4]  = '{C_DIV, 1'b0, 1'b0, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000, 16'hFFFD, 4'b0100, 17};
        vectors[5]  = '{C_DIV, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'b0101, 1};
        vectors[6]  = '{C_DIV, 1'b0, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 4'b0101, 17};
        vectors[7]  = '{C_AND, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1};
        vectors[8]  = '{C_OR,  1'b0, 1'b0, 16'h1200, 16'h0034, 16'h0000, 16'h0000, 16'h1234, 4'b0000, 1};
        vectors[9]  = '{C_XOR, 1'b0, 1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 1};
        vectors[10] = '{C_LSL, 1'b0, 1'b0, 16'h8001, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 4'b0010, 1};
        vectors[11] = '{C_LSR, 1'b0, 1'b0, 16'h0003, 16'h0011, 16'h0000, 16'h0000, 16'h0001, 4'b0010, 1};
        vectors[12] = '{C_LSL, 1'b0, 1'b0, 16'h8000, 16'h0010, 16'h0000, 16'h0000, 16'h8000, 4'b0100, 1};
        vectors[13] = '{C_SUB, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 1};
        vectors[14] = '{C_SUB, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 4'b0001, 1};
        vectors[15] = '{C_MUL, 1'b0, 1'b0, 16'h0007, 16'hFFFD, 16'h0000, 16'h0000, 16'hFFEB, 4'b0100, 17};
        vectors[16] = '{C_BAD, 1'b0, 1'b0, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'hFFEB, 4'b0000, 1};
        vectors[17] = '{C_DIV, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFF9, 16'h0003, 16'hFFFE, 4'b0100, 17};
        rand_ops = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_LSL, C_LSR, C_MUL, C_DIV, 6'h00, C_BAD};

        // Reset must win over START and EN.
        RST = 1'b1; EN = 1'b0; START = 1'b1; OPCODE = C_ADD;
        ACC = 16'h1111; X = 16'h2222; Y = 16'h0; IMMEDIATE = 16'h0;
        REGISTER_ADDRESS = 1'b0; USE_IMM = 1'b0;
        tick(); tick();
        checkOutput("reset_res", 32'(res), 32'h0);
        checkOutput("reset_flags", 32'(flags), 32'h0);
        checkOutput("reset_busy", 32'(BUSY), 32'h0);
        checkOutput("reset_done", 32'(DONE), 32'h0);
        RST = 1'b0; START = 1'b0; EN = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vectors[i].op, vectors[i].acc, vectors[i].x, vectors[i].y, vectors[i].imm,
                          vectors[i].ra, vectors[i].ui, lat, busy_cycles, got_res, got_flags);
            checkOutput($sformatf("vec%0d_res", i), 32'(got_res), 32'(vectors[i].exp_res));
            checkOutput($sformatf("vec%0d_flags", i), 32'(got_flags), 32'(vectors[i].exp_flags));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vectors[i].exp_lat));
            checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(busy_cycles),
                        (vectors[i].exp_lat == 17) ? 32'd16 : 32'd0);
        end

        prev_res = vectors[NVEC-1].exp_res;
        for (int n = 0; n < 40; n++) begin
            op = rand_ops[$urandom_range(0, 10)];
            acc = pick(); x = pick(); y = pick(); imm = pick();
            ra = 1'($urandom_range(0, 1));
            ui = 1'($urandom_range(0, 1));
            a = ui ? (ra ? y : x) : acc;
            b = ui ? imm : (ra ? y : x);
            refModel(op, a, b, prev_res, e_res, e_flags, e_lat);
            applyStimulus(op, acc, x, y, imm, ra, ui, lat, busy_cycles, got_res, got_flags);
            checkOutput($sformatf("rand%0d_op%0h_res", n, op), 32'(got_res), 32'(e_res));
            checkOutput($sformatf("rand%0d_op%0h_flags", n, op), 32'(got_flags), 32'(e_flags));
            checkOutput($sformatf("rand%0d_op%0h_latency", n, op), 32'(lat), 32'(e_lat));
            prev_res = e_res;
        end

        // Back-to-back single-cycle ops with START held: 12+5, 12-5, 12^5.
        ACC = 16'd12; X = 16'd5; USE_IMM = 1'b0; REGISTER_ADDRESS = 1'b0;
        OPCODE = C_ADD; START = 1'b1;
        tick();
        OPCODE = C_SUB;
        tick();
        checkOutput("b2b_add_done", 32'(DONE), 32'h1);
        checkOutput("b2b_add_res", 32'(res), 32'd17);
        OPCODE = C_XOR;
        tick();
        checkOutput("b2b_sub_done", 32'(DONE), 32'h1);
        checkOutput("b2b_sub_res", 32'(res), 32'd7);
        START = 1'b0;
        tick();
        checkOutput("b2b_xor_done", 32'(DONE), 32'h1);
        checkOutput("b2b_xor_res", 32'(res), 32'd9);
        tick();
        checkOutput("hold_done_low", 32'(DONE), 32'h0);
        checkOutput("hold_res", 32'(res), 32'd9);

        // Reset in the 5th BUSY cycle of a MUL aborts it without DONE.
        OPCODE = C_MUL; ACC = 16'd3; X = 16'd4; START = 1'b1;
        tick();
        START = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (BUSY) busy_seen++;
        end
        checkOutput("mulabort_busy_before", 32'(busy_seen), 32'd5);
        RST = 1'b1;
        tick();
        checkOutput("mulabort_busy", 32'(BUSY), 32'h0);
        checkOutput("mulabort_res", 32'(res), 32'h0);
        checkOutput("mulabort_flags", 32'(flags), 32'h0);
        checkOutput("mulabort_done", 32'(DONE), 32'h0);
        RST = 1'b0;
        applyStimulus(C_ADD, 16'd1, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0, lat, busy_cycles, got_res, got_flags);
        checkOutput("postrst_add_res", 32'(got_res), 32'd2);
        checkOutput("postrst_add_latency", 32'(lat), 32'd1);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE) done_seen++;
        end
        checkOutput("mulabort_no_late_done", 32'(done_seen), 32'd0);

        // DIV 100/7 with an ignored START mid-run and three EN=0 cycles.
        OPCODE = C_DIV; ACC = 16'd100; X = 16'd7; USE_IMM = 1'b0; REGISTER_ADDRESS = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        OPCODE = C_ADD; ACC = 16'd0; X = 16'd0; START = 1'b1;
        tick();
        lat++;
        START = 1'b0;
        tick();
        lat++;
        EN = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
            if (BUSY) busy_seen++;
        end
        checkOutput("div_en_freeze_busy", 32'(busy_seen), 32'd3);
        EN = 1'b1;
        while (lat < 60) begin
            tick();
            lat++;
            if (DONE) break;
        end
        checkOutput("div_en_latency", 32'(lat), 32'd20);
        checkOutput("div_en_res", 32'(res), 32'h000E);
        checkOutput("div_en_flags", 32'(flags), 32'h0);
        tick();
        checkOutput("div_en_after_done", 32'(DONE), 32'h0);
        checkOutput("div_en_after_busy", 32'(BUSY), 32'h0);
        checkOutput("div_en_after_res", 32'(res), 32'h000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
